ber_err_acc: RTL and testbench

- Up-counting measurement block for the BER checker.
- Opens a window of a programmed number of received bits, counts the bits and the bit errors inside it, and captures the totals into result registers at window end.
- Sits downstream of the pattern comparator and is the accumulating counterpart of the window/timeout down-counters.
- Results are read by the register/report logic.

---
 rtl/ber_err_acc.sv | 152 +++++++++++++++
 tb/tb_ber_err_acc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ber_err_acc.sv
// ---------------------------------------------------------------------------
// ber_err_acc
//   Windowed bit/error accumulator for the BER checker. A START opens a
//   window of WIN valid bits; every valid compared bit from the pattern
//   comparator bumps the bit counter, and errored bits bump a saturating
//   error counter. When the WIN-th valid bit arrives, the totals are captured
//   into the RES_* registers and DONE pulses for one cycle.
//
// Ports
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   START     pulse: open a new window, latch WIN
//   ABORT     pulse: close the window without capturing results
//   WIN       window length in valid bits (sampled with START)
//   BIT_VLD   one compared bit present this cycle
//   BIT_ERR   that bit mismatched (ignored when BIT_VLD=0)
//   BUSY      high while a window is running
//   DONE      one-cycle pulse, results just captured
//   BIT_CNT   live valid-bit count of the current window
//   ERR_CNT   live (saturating) error count of the current window
//   RES_BITS  captured bit count
//   RES_ERR   captured error count
//   RES_OVF   captured error-saturation flag
// ---------------------------------------------------------------------------
module ber_err_acc #(
    parameter int BW_BIT = 32,
    parameter int BW_ERR = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [BW_BIT-1:0] WIN,
    input  logic              BIT_VLD,
    input  logic              BIT_ERR,
    output logic              BUSY,
    output logic              DONE,
    output logic [BW_BIT-1:0] BIT_CNT,
    output logic [BW_ERR-1:0] ERR_CNT,
    output logic [BW_BIT-1:0] RES_BITS,
    output logic [BW_ERR-1:0] RES_ERR,
    output logic              RES_OVF
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            state;
    logic [BW_BIT-1:0] win_len;
    logic              ovf;

    logic [BW_BIT-1:0] bit_nxt;
    logic [BW_ERR-1:0] err_nxt;
    logic              ovf_nxt;
    logic [BW_ERR:0]   err_step_r;

    // Saturating error step. Returns {overflow_event, next_count}: an errored
    // bit arriving while the counter is already at full scale holds the count
    // and reports the overflow event instead.
    function automatic logic [BW_ERR:0] err_step(
        input logic [BW_ERR-1:0] cnt,
        input logic              hit
    );
        logic [BW_ERR:0] r;
        r = {1'b0, cnt};
        if (hit) begin
            if (cnt == {BW_ERR{1'b1}}) begin
                r = {1'b1, cnt};
            end else begin
                r = {1'b0, cnt + BW_ERR'(1)};
            end
        end
        return r;
    endfunction

    always_comb begin
        bit_nxt    = BIT_CNT + BW_BIT'(1);
        err_step_r = err_step(ERR_CNT, BIT_ERR);
        err_nxt    = err_step_r[BW_ERR-1:0];
        ovf_nxt    = ovf | err_step_r[BW_ERR];
    end

    // Priority: RST > ABORT > START > window end > counting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            BIT_CNT  <= '0;
            ERR_CNT  <= '0;
            RES_BITS <= '0;
            RES_ERR  <= '0;
            RES_OVF  <= 1'b0;
            win_len  <= '0;
            ovf      <= 1'b0;
        end else if (ABORT) begin
            // Live counters and results deliberately left untouched.
            state <= S_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else if (START) begin
            // Restart is allowed from any state, including mid-window.
            state   <= S_RUN;
            BUSY    <= 1'b1;
            DONE    <= 1'b0;
            BIT_CNT <= '0;
            ERR_CNT <= '0;
            ovf     <= 1'b0;
            win_len <= WIN;
        end else begin
            case (state)
                S_RUN: begin
                    if (win_len == '0) begin
                        // Empty window: close on the first RUN cycle without
                        // counting whatever bit is present.
                        state    <= S_FIN;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                        RES_BITS <= '0;
                        RES_ERR  <= '0;
                        RES_OVF  <= 1'b0;
                    end else if (BIT_VLD) begin
                        BIT_CNT <= bit_nxt;
                        ERR_CNT <= err_nxt;
                        ovf     <= ovf_nxt;
                        // Capture uses the post-increment values so the
                        // final bit is included in the results.
                        if (bit_nxt == win_len) begin
                            state    <= S_FIN;
                            BUSY     <= 1'b0;
                            DONE     <= 1'b1;
                            RES_BITS <= bit_nxt;
                            RES_ERR  <= err_nxt;
                            RES_OVF  <= ovf_nxt;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    DONE  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ber_err_acc.sv
module tb_ber_err_acc;

    localparam int BW_BIT = 16;
    localparam int BW_ERR = 4;
    localparam int MAXE   = (1 << BW_ERR) - 1;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              START = 1'b0;
    logic              ABORT = 1'b0;
    logic [BW_BIT-1:0] WIN = '0;
    logic              BIT_VLD = 1'b0;
    logic              BIT_ERR = 1'b0;
    logic              BUSY;
    logic              DONE;
    logic [BW_BIT-1:0] BIT_CNT;
    logic [BW_ERR-1:0] ERR_CNT;
    logic [BW_BIT-1:0] RES_BITS;
    logic [BW_ERR-1:0] RES_ERR;
    logic              RES_OVF;

    always #5 CLK = ~CLK;

    ber_err_acc #(.BW_BIT(BW_BIT), .BW_ERR(BW_ERR)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .WIN(WIN),
        .BIT_VLD(BIT_VLD), .BIT_ERR(BIT_ERR), .BUSY(BUSY), .DONE(DONE),
        .BIT_CNT(BIT_CNT), .ERR_CNT(ERR_CNT), .RES_BITS(RES_BITS),
        .RES_ERR(RES_ERR), .RES_OVF(RES_OVF)
    );

    typedef struct {
        int bits;
        int err;
        int ovf;
    } res_t;

    res_t q[$];

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    // Reference model: window state 0=idle 1=run 2=fin, raw (unsaturated)
    // error total, saturation derived from it when compared.
    int m_state = 0;
    int m_len   = 0;
    int m_bits  = 0;
    int m_errs  = 0;
    int m_rb    = 0;
    int m_re    = 0;
    int m_ro    = 0;

    function automatic int sat(input int n);
        return (n > MAXE) ? MAXE : n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic finish_win();
        res_t r;
        m_state = 2;
        m_rb    = m_bits;
        m_re    = sat(m_errs);
        m_ro    = (m_errs > MAXE) ? 1 : 0;
        r.bits  = m_rb;
        r.err   = m_re;
        r.ovf   = m_ro;
        q.push_back(r);
    endtask

    task automatic model_step(input bit r, input bit st, input bit ab,
                              input int w, input bit v, input bit e);
        if (r) begin
            m_state = 0; m_len = 0; m_bits = 0; m_errs = 0;
            m_rb = 0; m_re = 0; m_ro = 0;
            q.delete();
        end else if (ab) begin
            m_state = 0;
        end else if (st) begin
            m_state = 1; m_len = w; m_bits = 0; m_errs = 0;
        end else if (m_state == 1) begin
            if (m_len == 0) begin
                finish_win();
            end else if (v) begin
                m_bits++;
                m_errs += int'(e);
                if (m_bits == m_len) finish_win();
            end
        end else if (m_state == 2) begin
            m_state = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit st, input bit ab,
                       input int w, input bit v, input bit e);
        RST = r; START = st; ABORT = ab; WIN = BW_BIT'(w);
        BIT_VLD = v; BIT_ERR = e;
        @(posedge CLK);
        model_step(r, st, ab, w, v, e);
        if (r) mon_en = 1'b1;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic bits(input int n, input bit e);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, e);
    endtask

    // Monitor: live outputs against the model every cycle; captured results
    // popped from the scoreboard whenever DONE is presented.
    always @(negedge CLK) begin
        if (mon_en) begin
            res_t r;
            chk("busy",     int'(BUSY),     int'(m_state == 1));
            chk("done",     int'(DONE),     int'(m_state == 2));
            chk("bit_cnt",  int'(BIT_CNT),  m_bits);
            chk("err_cnt",  int'(ERR_CNT),  sat(m_errs));
            chk("res_bits", int'(RES_BITS), m_rb);
            chk("res_err",  int'(RES_ERR),  m_re);
            chk("res_ovf",  int'(RES_OVF),  m_ro);
            if (DONE) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL done_scoreboard: DONE seen with no expected result at %0t", $time);
                end else begin
                    r = q.pop_front();
                    chk("sb_bits", int'(RES_BITS), r.bits);
                    chk("sb_err",  int'(RES_ERR),  r.err);
                    chk("sb_ovf",  int'(RES_OVF),  r.ovf);
                end
            end
        end
    end

    initial begin
        // Reset
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(2);

        // Basic window: 10 bits, errors on bits 3 and 7, gaps between bits
        cyc(0, 1, 0, 10, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 1, (i == 3 || i == 7));
        end
        idle(3);

        // Saturation, then a clean window clears the flag at its DONE
        cyc(0, 1, 0, 20, 0, 0);
        bits(20, 1);
        idle(2);
        cyc(0, 1, 0, 5, 0, 0);
        bits(2, 0);
        idle(1);
        bits(3, 0);
        idle(2);

        // Restart mid-window, then abort
        cyc(0, 1, 0, 8, 0, 0);
        bits(5, 1);
        cyc(0, 1, 0, 3, 0, 0);
        bits(3, 0);
        idle(2);
        cyc(0, 1, 0, 6, 0, 0);
        bits(2, 1);
        cyc(0, 0, 1, 0, 0, 0);
        idle(3);

        // WIN=0, with a valid bit on the first RUN cycle
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        idle(3);

        // START and ABORT together
        cyc(0, 1, 1, 5, 0, 0);
        idle(2);

        // START on the final-bit cycle
        cyc(0, 1, 0, 4, 0, 0);
        bits(3, 1);
        cyc(0, 1, 0, 2, 1, 1);
        bits(2, 1);
        idle(2);

        // START in FIN
        cyc(0, 1, 0, 2, 0, 0);
        bits(2, 0);
        cyc(0, 1, 0, 3, 0, 0);
        bits(3, 1);
        idle(2);

        // Reset mid-window, then a full window
        cyc(0, 1, 0, 10, 0, 0);
        bits(4, 1);
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 1, 0, 10, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1, (i % 3 == 0));
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, st, ab, v, e;
            int w;
            r  = ($urandom_range(0, 299) == 0);
            st = ($urandom_range(0, 24) == 0);
            ab = ($urandom_range(0, 79) == 0);
            w  = $urandom_range(0, 25);
            v  = ($urandom_range(0, 99) < 65);
            e  = ($urandom_range(0, 99) < 60);
            cyc(r, st, ab, w, v, e);
        end
        idle(3);

        #1;
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
